// File: rtl/datamemory_mc.sv
// Multi-cycle byte-addressed data memory for the MEM stage.
// Requests are accepted in IDLE, held for WAIT_CYCLES extra cycles and
// answered with a one-cycle rsp_valid pulse from RESP. Loads and stores
// follow RV32I byte/half/word formatting, with misalignment and illegal
// funct3 reported through fault.
//
// Handshake: a request is present while MemRead|MemWrite is high in IDLE;
// stall rises combinationally in that same cycle and stays high until the
// response cycle, where rsp_valid=1 and stall=0. The requester keeps the
// request asserted until it sees rsp_valid and drops it afterwards; the
// inputs are ignored during RESP. fault is meaningful only with rsp_valid.
module datamemory_mc #(
    parameter int DM_ADDRESS  = 9,
    parameter int DATA_W      = 32,
    parameter int WAIT_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  MemRead,
    input  logic                  MemWrite,
    input  logic [DM_ADDRESS-1:0] a,
    input  logic [DATA_W-1:0]     wd,
    input  logic [2:0]            Funct3,
    output logic [DATA_W-1:0]     rd,
    output logic                  rsp_valid,
    output logic                  stall,
    output logic                  fault
);

    localparam int DEPTH = 2 ** (DM_ADDRESS - 2);

    if (DATA_W != 32) begin : g_bad_width
        $error("datamemory_mc: only DATA_W=32 is supported");
    end
    if (WAIT_CYCLES < 0 || WAIT_CYCLES > 15) begin : g_bad_wait
        $error("datamemory_mc: WAIT_CYCLES must be within 0..15");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [DATA_W-1:0] rd_q, rd_d;
    logic fault_q, fault_d;
    logic stall_raw;

    // Request captured at acceptance, used while waiting.
    logic [DM_ADDRESS-1:0] a_q;
    logic [DATA_W-1:0]     wd_q;
    logic [2:0]            f3_q;
    logic                  load_q;

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic req;
    logic [DM_ADDRESS-1:0] eff_a;
    logic [DATA_W-1:0]     eff_wd;
    logic [2:0]            eff_f3;
    logic                  eff_load;
    logic                  do_access;
    logic                  misaligned;
    logic                  illegal;
    logic                  acc_fault;
    logic [DATA_W-1:0]     word;
    logic [7:0]            byte_sel;
    logic [15:0]           half_sel;
    logic [DATA_W-1:0]     ld_data;
    logic [3:0]            be;
    logic [DATA_W-1:0]     wdata;
    logic                  mem_we;

    assign req = MemRead | MemWrite;

    // Operand view of the access: live inputs in IDLE (zero-wait case),
    // captured copy otherwise.
    always_comb begin
        eff_a    = a_q;
        eff_wd   = wd_q;
        eff_f3   = f3_q;
        eff_load = load_q;
        if (state_q == IDLE) begin
            eff_a    = a;
            eff_wd   = wd;
            eff_f3   = Funct3;
            eff_load = MemRead;
        end
    end

    // Access happens at the edge that leaves the wait period.
    assign do_access = ((state_q == IDLE) && req && (WAIT_CYCLES == 0)) ||
                       ((state_q == WAIT) && (cnt_q == 4'd1));

    // Fault decode: alignment against element size, legal funct3 per op.
    always_comb begin
        misaligned = 1'b0;
        illegal    = 1'b0;
        case (eff_f3)
            3'b000: misaligned = 1'b0;
            3'b001: misaligned = eff_a[0];
            3'b010: misaligned = |eff_a[1:0];
            3'b100: illegal    = ~eff_load;
            3'b101: begin
                illegal    = ~eff_load;
                misaligned = eff_load & eff_a[0];
            end
            default: illegal = 1'b1;
        endcase
    end

    assign acc_fault = misaligned | illegal;

    // Load formatting: the sign comes from the selected element's MSB.
    always_comb begin
        word = mem_q[eff_a[DM_ADDRESS-1:2]];
        case (eff_a[1:0])
            2'd0:    byte_sel = word[7:0];
            2'd1:    byte_sel = word[15:8];
            2'd2:    byte_sel = word[23:16];
            default: byte_sel = word[31:24];
        endcase
        half_sel = eff_a[1] ? word[31:16] : word[15:0];
        case (eff_f3)
            3'b000:  ld_data = {{24{byte_sel[7]}}, byte_sel};
            3'b100:  ld_data = {24'b0, byte_sel};
            3'b001:  ld_data = {{16{half_sel[15]}}, half_sel};
            3'b101:  ld_data = {16'b0, half_sel};
            default: ld_data = word;
        endcase
    end

    // Store lane enables and replicated write data.
    always_comb begin
        be    = 4'b1111;
        wdata = eff_wd;
        case (eff_f3)
            3'b000: begin
                be    = 4'b0001 << eff_a[1:0];
                wdata = {4{eff_wd[7:0]}};
            end
            3'b001: begin
                be    = eff_a[1] ? 4'b1100 : 4'b0011;
                wdata = {2{eff_wd[15:0]}};
            end
            default: begin
                be    = 4'b1111;
                wdata = eff_wd;
            end
        endcase
    end

    assign mem_we = do_access & ~eff_load & ~acc_fault;

    // Next state, wait counter, response data and stall.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rd_d      = rd_q;
        fault_d   = fault_q;
        stall_raw = 1'b0;
        case (state_q)
            IDLE: begin
                if (req) begin
                    stall_raw = 1'b1;
                    cnt_d     = 4'(WAIT_CYCLES);
                    state_d   = (WAIT_CYCLES == 0) ? RESP : WAIT;
                end
            end
            WAIT: begin
                stall_raw = 1'b1;
                cnt_d     = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (do_access) begin
            fault_d = acc_fault;
            if (eff_load && !acc_fault) begin
                rd_d = ld_data;
            end
        end
    end

    // Control state with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            rd_q    <= '0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rd_q    <= rd_d;
            fault_q <= fault_d;
        end
    end

    // Capture the request operands when it is accepted.
    always_ff @(posedge clk) begin
        if (state_q == IDLE && req) begin
            a_q    <= a;
            wd_q   <= wd;
            f3_q   <= Funct3;
            load_q <= MemRead;
        end
    end

    // Byte-lane store into storage; blocked while reset is asserted.
    always_ff @(posedge clk) begin
        if (rst_n && mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem_q[eff_a[DM_ADDRESS-1:2]][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    assign rd        = rd_q;
    assign rsp_valid = (state_q == RESP);
    assign fault     = fault_q & (state_q == RESP);
    assign stall     = rst_n & stall_raw;

endmodule
